mbf_frame_sched: RTL and testbench

Frame scheduler for the shared 16-tap LPF/HPF multi-bank filter datapath. Two requesters each submit a frame (base address, length) of 8-bit signed samples held in the sample ROM. The block arbitrates round-robin and clears the filter accumulators. It then streams the frame's samples followed by TAPS-1 zero flush samples, tags the filter outputs with the owning requester, decimates them and signals frame completion. It sits between the requesters, the sample ROM and the filter datapath.

---
 rtl/mbf_pkg.sv | 40 ++++
 rtl/mbf_frame_sched_if.sv | 35 +++
 rtl/mbf_rr_arb.sv | 36 +++
 rtl/mbf_frame_sched.sv | 156 +++++++++++++++
 tb/tb_mbf_frame_sched.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/mbf_pkg.sv
// Shared constants and types for the multi-bank filter frame scheduler.
//   TAPS  : filter length; a frame is followed by TAPS-1 zero flush samples
//   LAT   : datapath delay from a fir_en cycle to its y/z output
//   DECIM : only output indices k with k%DECIM==0 are flagged valid
//   AW/LW : ROM address width / frame length width
package mbf_pkg;

    localparam int unsigned TAPS  = 16;
    localparam int unsigned LAT   = 16;
    localparam int unsigned DECIM = 2;
    localparam int unsigned AW    = 10;
    localparam int unsigned LW    = 10;
    localparam int unsigned KW    = LW + 1;
    localparam int unsigned DW    = 8;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        RUN,
        FLUSH,
        DRAIN,
        DONE
    } state_t;

    typedef logic req_id_t;

    // One entry of the output-tagging delay line.
    typedef struct packed {
        logic    valid;
        req_id_t tag;
        logic    kept;
        logic    last;
    } tag_ent_t;

    // Requester id to one-hot grant vector.
    function automatic logic [1:0] id_onehot(input req_id_t id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mbf_frame_sched_if.sv
// Requester / ROM / filter-datapath signal bundle of the frame scheduler.
//   master : requesters, sample ROM and filter datapath side
//   slave  : the scheduler
interface mbf_frame_sched_if;
    import mbf_pkg::*;

    logic [1:0]    req;
    logic [AW-1:0] base0;
    logic [AW-1:0] base1;
    logic [LW-1:0] len0;
    logic [LW-1:0] len1;
    logic [1:0]    gnt;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_q;
    logic          fir_clr;
    logic          fir_en;
    logic [DW-1:0] fir_x;
    logic          out_valid;
    logic          out_tag;
    logic [1:0]    done;

    modport master (
        output req, base0, base1, len0, len1, rom_q,
        input  gnt, rom_en, rom_addr, fir_clr, fir_en, fir_x,
               out_valid, out_tag, done
    );

    modport slave (
        input  req, base0, base1, len0, len1, rom_q,
        output gnt, rom_en, rom_addr, fir_clr, fir_en, fir_x,
               out_valid, out_tag, done
    );

endinterface

// File: rtl/mbf_rr_arb.sv
// Two-way round-robin picker.
//   req      : request levels
//   grant_en : a grant is being taken this cycle; the pointer moves only then
//   pick_c   : winning requester id (combinational)
module mbf_rr_arb
    import mbf_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic [1:0] req,
    input  logic    grant_en,
    output req_id_t pick_c
);

    req_id_t last;

    // On contention the requester not served last wins; a lone request wins.
    always_comb begin
        pick_c = 1'b0;
        if (req == 2'b11) begin
            pick_c = ~last;
        end else if (req == 2'b10) begin
            pick_c = 1'b1;
        end
    end

    // Pointer starts at 1 so requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            last <= 1'b1;
        end else if (grant_en) begin
            last <= pick_c;
        end
    end

endmodule

// File: rtl/mbf_frame_sched.sv
// Frame scheduler for the shared LPF/HPF filter datapath.
// Arbitrates two requesters, clears the accumulators, streams the frame's ROM
// samples followed by TAPS-1 zeros, tags the delayed outputs with the owner
// and decimation flag, and pulses done when the last output emerges.
//   clk, reset : clock, synchronous active-high reset
//   bus        : requester, ROM and datapath signals (slave side)
module mbf_frame_sched
    import mbf_pkg::*;
(
    input  logic clk,
    input  logic reset,
    mbf_frame_sched_if.slave bus
);

    state_t        state;
    req_id_t       owner;
    req_id_t       pick;
    logic [AW-1:0] base_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] scnt;
    logic [KW-1:0] fcnt;
    logic [KW-1:0] kcnt;
    logic [KW-1:0] klast;
    logic          flush;
    logic          rom_en_d;
    logic          flush_d;
    logic          fir_en_c;
    tag_ent_t      head;
    tag_ent_t      sr [LAT];

    mbf_rr_arb u_arb (
        .clk      (clk),
        .reset    (reset),
        .req      (bus.req),
        .grant_en ((state == IDLE) && (|bus.req)),
        .pick_c   (pick)
    );

    // ROM data arrives one cycle after rom_en; flush zeros line up the same way.
    assign fir_en_c   = rom_en_d | flush_d;
    assign bus.fir_en = fir_en_c;
    assign bus.fir_x  = rom_en_d ? bus.rom_q : '0;

    // Frame control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            owner        <= 1'b0;
            base_q       <= '0;
            len_q        <= '0;
            scnt         <= '0;
            fcnt         <= '0;
            klast        <= '0;
            flush        <= 1'b0;
            bus.gnt      <= '0;
            bus.rom_en   <= 1'b0;
            bus.rom_addr <= '0;
            bus.fir_clr  <= 1'b0;
            bus.done     <= '0;
        end else begin
            bus.fir_clr <= 1'b0;
            bus.done    <= '0;
            unique case (state)
                IDLE: begin
                    if (|bus.req) begin
                        owner       <= pick;
                        bus.gnt     <= id_onehot(pick);
                        base_q      <= pick ? bus.base1 : bus.base0;
                        len_q       <= pick ? bus.len1 : bus.len0;
                        klast       <= KW'(pick ? bus.len1 : bus.len0) + KW'(TAPS - 2);
                        bus.fir_clr <= 1'b1;
                        state       <= CLR;
                    end
                end
                CLR: begin
                    if (len_q == '0) begin
                        bus.done <= bus.gnt;
                        state    <= DONE;
                    end else begin
                        bus.rom_en   <= 1'b1;
                        bus.rom_addr <= base_q;
                        scnt         <= '0;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    if (scnt == len_q - LW'(1)) begin
                        bus.rom_en <= 1'b0;
                        flush      <= 1'b1;
                        fcnt       <= '0;
                        state      <= FLUSH;
                    end else begin
                        scnt         <= scnt + LW'(1);
                        bus.rom_addr <= bus.rom_addr + AW'(1);
                    end
                end
                FLUSH: begin
                    if (fcnt == KW'(TAPS - 2)) begin
                        flush <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        fcnt <= fcnt + KW'(1);
                    end
                end
                DRAIN: begin
                    if (sr[LAT-1].valid && sr[LAT-1].last) begin
                        bus.done <= bus.gnt;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    bus.gnt <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag entry describing the sample entering the datapath this cycle.
    always_comb begin
        head       = '0;
        head.valid = fir_en_c;
        head.tag   = owner;
        head.kept  = (kcnt % KW'(DECIM)) == '0;
        head.last  = fir_en_c && (kcnt == klast);
    end

    // Input delay stage, output index counter and LAT-deep tag delay line.
    always_ff @(posedge clk) begin
        if (reset) begin
            rom_en_d <= 1'b0;
            flush_d  <= 1'b0;
            kcnt     <= '0;
            for (int unsigned i = 0; i < LAT; i++) begin
                sr[i] <= '0;
            end
        end else begin
            rom_en_d <= bus.rom_en;
            flush_d  <= flush;
            if (bus.fir_clr) begin
                kcnt <= '0;
            end else if (fir_en_c) begin
                kcnt <= kcnt + KW'(1);
            end
            sr[0] <= head;
            for (int unsigned i = 1; i < LAT; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign bus.out_valid = sr[LAT-1].valid & sr[LAT-1].kept;
    assign bus.out_tag   = sr[LAT-1].tag;

endmodule

// File: tb/tb_mbf_frame_sched.sv
// Scoreboard bench for mbf_frame_sched: each frame's expected grant, ROM
// addresses, datapath samples, tagged outputs and done pulse are queued with
// their cycle numbers when the request is driven, then popped as the DUT
// produces them.
module tb_mbf_frame_sched;
    import mbf_pkg::*;

    typedef struct {
        int          cyc;
        logic [31:0] val;
    } ev_t;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   t0, d0, d1, d2;

    ev_t q_clr[$];
    ev_t q_rom[$];
    ev_t q_fir[$];
    ev_t q_out[$];
    ev_t q_done[$];

    mbf_frame_sched_if ifc ();

    mbf_frame_sched dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] rom_fn(input logic [9:0] a);
        return 8'(a) ^ 8'(a >> 2) ^ 8'h5A;
    endfunction

    // Sample ROM: one-cycle read latency.
    always @(posedge clk) begin
        if (ifc.rom_en === 1'b1) ifc.rom_q <= rom_fn(ifc.rom_addr);
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_ev(input int kind, input int c, input logic [31:0] v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        case (kind)
            0: q_clr.push_back(e);
            1: q_rom.push_back(e);
            2: q_fir.push_back(e);
            3: q_out.push_back(e);
            default: q_done.push_back(e);
        endcase
    endtask

    // Pop the next expected event of a kind and compare {cycle, value}.
    task automatic pop_check(input int kind, input string tag, input logic [31:0] obs);
        ev_t e;
        bit  have;
        have = 1'b0;
        case (kind)
            0: if (q_clr.size() > 0)  begin e = q_clr.pop_front();  have = 1'b1; end
            1: if (q_rom.size() > 0)  begin e = q_rom.pop_front();  have = 1'b1; end
            2: if (q_fir.size() > 0)  begin e = q_fir.pop_front();  have = 1'b1; end
            3: if (q_out.size() > 0)  begin e = q_out.pop_front();  have = 1'b1; end
            default: if (q_done.size() > 0) begin e = q_done.pop_front(); have = 1'b1; end
        endcase
        if (have) check_val(tag, {32'(cyc), obs}, {32'(e.cyc), e.val});
        else      check_val({tag, "_unexpected"}, {32'(cyc), obs}, {32'hFFFF_FFFF, obs});
    endtask

    // Expected events of one frame whose request is first seen in IDLE cycle t.
    task automatic expect_frame(input int id, input int t, input logic [9:0] base,
                                input int len, output int done_cyc);
        logic [9:0] a;
        logic [1:0] oh;
        oh = (id == 1) ? 2'b10 : 2'b01;
        push_ev(0, t + 1, 32'(oh));
        if (len == 0) begin
            done_cyc = t + 2;
        end else begin
            for (int i = 0; i < len; i++) begin
                a = base + 10'(i);
                push_ev(1, t + 2 + i, 32'(a));
                push_ev(2, t + 3 + i, 32'(rom_fn(a)));
            end
            for (int j = 0; j < int'(TAPS) - 1; j++) push_ev(2, t + 3 + len + j, 32'd0);
            for (int k = 0; k <= len + int'(TAPS) - 2; k++) begin
                if (k % int'(DECIM) == 0) push_ev(3, t + 3 + k + int'(LAT), 32'(id));
            end
            done_cyc = t + len + int'(TAPS) + 2 + int'(LAT);
        end
        push_ev(4, done_cyc, 32'({oh, oh}));
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) next_cyc();
    endtask

    // Output monitor, away from the active edge.
    always @(negedge clk) begin
        if (ifc.fir_clr === 1'b1)   pop_check(0, "clr_gnt", 32'(ifc.gnt));
        if (ifc.rom_en === 1'b1)    pop_check(1, "rom_addr", 32'(ifc.rom_addr));
        if (ifc.fir_en === 1'b1)    pop_check(2, "fir_x", 32'(ifc.fir_x));
        if (ifc.out_valid === 1'b1) pop_check(3, "out_tag", 32'(ifc.out_tag));
        if (ifc.done !== 2'b00)     pop_check(4, "done_gnt", 32'({ifc.done, ifc.gnt}));
    end

    always @(posedge clk) begin
        if (cyc > 4000) begin
            $display("FAIL watchdog: cycle %0d reached without finishing", cyc);
            $fatal(1);
        end
    end

    initial begin
        reset     = 1'b1;
        ifc.req   = 2'b00;
        ifc.base0 = '0;
        ifc.base1 = '0;
        ifc.len0  = '0;
        ifc.len1  = '0;
        ifc.rom_q = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_val("reset_state",
                  64'({ifc.gnt, ifc.rom_en, ifc.rom_addr, ifc.fir_clr, ifc.fir_en,
                       ifc.fir_x, ifc.out_valid, ifc.out_tag, ifc.done}), 64'd0);
        next_cyc();

        // Simultaneous requests from reset: 0 first, then 1.
        t0 = cyc;
        ifc.base0 = 10'h040; ifc.len0 = 10'd2;
        ifc.base1 = 10'h2A0; ifc.len1 = 10'd2;
        ifc.req   = 2'b11;
        expect_frame(0, t0, 10'h040, 2, d0);
        expect_frame(1, d0 + 1, 10'h2A0, 2, d1);
        wait_cyc(d0); ifc.req[0] = 1'b0;
        wait_cyc(d1); ifc.req[1] = 1'b0;
        wait_cyc(d1 + 2);

        // Reference frame: base 0x100, len 4.
        t0 = cyc;
        ifc.base0 = 10'h100; ifc.len0 = 10'd4; ifc.req = 2'b01;
        expect_frame(0, t0, 10'h100, 4, d0);
        wait_cyc(d0); ifc.req = 2'b00;
        wait_cyc(d0 + 2);

        // req0 held, req1 raised mid-frame: grants 0,1,0.
        t0 = cyc;
        ifc.base0 = 10'h010; ifc.len0 = 10'd1; ifc.req = 2'b01;
        expect_frame(0, t0, 10'h010, 1, d0);
        wait_cyc(t0 + 10);
        ifc.base1 = 10'h300; ifc.len1 = 10'd3; ifc.req = 2'b11;
        expect_frame(1, d0 + 1, 10'h300, 3, d1);
        expect_frame(0, d1 + 1, 10'h010, 1, d2);
        wait_cyc(d1); ifc.req[1] = 1'b0;
        wait_cyc(d2); ifc.req = 2'b00;
        wait_cyc(d2 + 2);

        // Zero-length frame.
        t0 = cyc;
        ifc.base0 = 10'h0AA; ifc.len0 = 10'd0; ifc.req = 2'b01;
        expect_frame(0, t0, 10'h0AA, 0, d0);
        wait_cyc(d0); ifc.req = 2'b00;
        wait_cyc(d0 + 2);

        // Address wrap past the top of the ROM, requester 1.
        t0 = cyc;
        ifc.base1 = 10'h3FE; ifc.len1 = 10'd4; ifc.req = 2'b10;
        expect_frame(1, t0, 10'h3FE, 4, d0);
        wait_cyc(d0); ifc.req = 2'b00;
        wait_cyc(d0 + 2);

        // Reset during RUN aborts the frame without a done pulse.
        t0 = cyc;
        ifc.base0 = 10'h155; ifc.len0 = 10'd8; ifc.req = 2'b01;
        push_ev(0, t0 + 1, 32'd1);
        push_ev(1, t0 + 2, 32'h155);
        push_ev(1, t0 + 3, 32'h156);
        push_ev(2, t0 + 3, 32'(rom_fn(10'h155)));
        wait_cyc(t0 + 3);
        reset   = 1'b1;
        ifc.req = 2'b00;
        next_cyc();
        reset = 1'b0;
        @(negedge clk);
        check_val("abort_idle", 64'({ifc.gnt, ifc.rom_en, ifc.fir_en, ifc.done, ifc.out_valid}), 64'd0);
        next_cyc();
        wait_cyc(t0 + 70);

        check_val("left_clr",  64'(q_clr.size()),  64'd0);
        check_val("left_rom",  64'(q_rom.size()),  64'd0);
        check_val("left_fir",  64'(q_fir.size()),  64'd0);
        check_val("left_out",  64'(q_out.size()),  64'd0);
        check_val("left_done", 64'(q_done.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
